z80_bus_tracer: RTL and testbench

Passive bus-cycle capture stage that sits directly downstream of the `tv80s` core, on the same pins that drive the testbench memory/IO model. Each completed CPU bus cycle becomes one record: cycle type, address, data and start timestamp. Records go into an internal FIFO and are drained over a valid/ready stream. Refresh cycles are filtered out, and dropped records are counted.

---
 rtl/z80_bus_tracer.sv | 170 +++++++++++++++++
 tb/tb_z80_bus_tracer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_tracer.sv
// Passive tv80s bus-cycle tracer: decodes strobes into records {ts, type, addr, data}
// and queues them in a first-word-fall-through FIFO with drop accounting.
module z80_bus_tracer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TSW   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     m1_n,
  input  logic                     mreq_n,
  input  logic                     iorq_n,
  input  logic                     rd_n,
  input  logic                     wr_n,
  input  logic                     rfsh_n,
  input  logic [15:0]              A,
  input  logic [7:0]               di,
  input  logic [7:0]               dout,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [27+TSW-1:0]        rec_data,
  output logic [$clog2(DEPTH):0]   rec_count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = 27 + TSW;

  localparam logic [2:0] T_OPF   = 3'd0;
  localparam logic [2:0] T_MEMRD = 3'd1;
  localparam logic [2:0] T_MEMWR = 3'd2;
  localparam logic [2:0] T_IORD  = 3'd3;
  localparam logic [2:0] T_IOWR  = 3'd4;
  localparam logic [2:0] T_INTA  = 3'd5;

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_ACTIVE} state_t;

  // rd_n carries no information beyond what mreq_n/iorq_n/wr_n already give
  logic unused_rd;
  assign unused_rd = rd_n;

  state_t           state_q, state_d;
  logic [TSW-1:0]   tcnt_q;
  logic [TSW-1:0]   hts_q, hts_d;
  logic [2:0]       typ_q, typ_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       data_q, data_d;

  logic             act_c, same_c, upgrade_c, start_c, push_c;
  logic [2:0]       typ_c;

  function automatic logic is_wr(input logic [2:0] t);
    return (t == T_MEMWR) || (t == T_IOWR);
  endfunction

  // Strobe decode; refresh requests never count as activity
  always_comb begin
    act_c = (!mreq_n && rfsh_n) || !iorq_n;
    typ_c = T_IORD;
    if (!m1_n && !mreq_n)       typ_c = T_OPF;
    else if (!m1_n && !iorq_n)  typ_c = T_INTA;
    else if (!mreq_n && !wr_n)  typ_c = T_MEMWR;
    else if (!mreq_n)           typ_c = T_MEMRD;
    else if (!iorq_n && !wr_n)  typ_c = T_IOWR;
    else                        typ_c = T_IORD;
  end

  always_comb begin
    state_d   = state_q;
    hts_d     = hts_q;
    typ_d     = typ_q;
    addr_d    = addr_q;
    data_d    = data_q;
    push_c    = 1'b0;
    start_c   = 1'b0;
    upgrade_c = ((typ_q == T_MEMRD) && (typ_c == T_MEMWR)) ||
                ((typ_q == T_IORD)  && (typ_c == T_IOWR));
    same_c    = act_c && (addr_q == A) && ((typ_c == typ_q) || upgrade_c);
    case (state_q)
      S_SYNC: if (!act_c) state_d = S_IDLE;
      S_IDLE: if (act_c && en) begin
        state_d = S_ACTIVE;
        start_c = 1'b1;
      end
      S_ACTIVE: begin
        if (same_c) begin
          if (upgrade_c) typ_d = typ_c;
          data_d = is_wr(typ_d) ? dout : di;
        end else begin
          push_c = 1'b1;
          if (!act_c || !en) begin
            state_d = S_IDLE;
          end else begin
            start_c = 1'b1;
          end
        end
      end
      default: state_d = S_SYNC;
    endcase
    if (start_c) begin
      hts_d  = tcnt_q;
      typ_d  = typ_c;
      addr_d = A;
      data_d = is_wr(typ_c) ? dout : di;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SYNC;
      tcnt_q  <= '0;
      hts_q   <= '0;
      typ_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_q + TSW'(1);
      hts_q   <= hts_d;
      typ_q   <= typ_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // FIFO: a push into a full FIFO succeeds only if the head leaves on the same edge
  logic [RW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic [7:0]    drop_q;
  logic          pop_c, full_c, wr_c, drop_c;

  assign pop_c  = (count_q != '0) && rec_ready;
  assign full_c = (count_q == CW'(DEPTH));
  assign wr_c   = push_c && (!full_c || pop_c);
  assign drop_c = push_c && full_c && !pop_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      if (wr_c) begin
        mem_q[wr_ptr_q] <= {hts_q, typ_q, addr_q, data_q};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_c && !pop_c)      count_q <= count_q + CW'(1);
      else if (!wr_c && pop_c) count_q <= count_q - CW'(1);
      if (drop_c) begin
        ovf_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end
  end

  assign rec_valid = (count_q != '0);
  assign rec_count = count_q;
  assign rec_data  = mem_q[rd_ptr_q];
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_z80_bus_tracer.sv
// Directed self-checking bench for z80_bus_tracer; inputs driven and outputs sampled on negedge.
module tb_z80_bus_tracer;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TSW   = 16;
  localparam int unsigned RW    = 27 + TSW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, en = 1'b0;
  logic m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1;
  logic [15:0] A = '0;
  logic [7:0] di = '0, dout = '0;
  logic rec_ready = 1'b0;
  logic rec_valid, overflow;
  logic [RW-1:0] rec_data;
  logic [4:0] rec_count;
  logic [7:0] drop_cnt;

  int chk_cnt = 0;
  int pass_cnt = 0;

  z80_bus_tracer #(.DEPTH(DEPTH), .TSW(TSW)) dut (
    .clk(clk), .reset(reset), .en(en),
    .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
    .A(A), .di(di), .dout(dout),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
    .rec_count(rec_count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  // Reference timestamp: value a cycle starting on the next edge will carry
  logic [TSW-1:0] tsm;
  always @(posedge clk) tsm <= reset ? '0 : tsm + 1'b1;

  task automatic bus_idle();
    m1_n = 1; mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1; rfsh_n = 1;
  endtask

  task automatic bus_drive(input logic [2:0] k, input logic [15:0] a, input logic [7:0] d);
    bus_idle();
    A = a;
    case (k)
      3'd0: begin m1_n = 0; mreq_n = 0; rd_n = 0; di = d; end
      3'd1: begin mreq_n = 0; rd_n = 0; di = d; end
      3'd2: begin mreq_n = 0; wr_n = 0; dout = d; end
      3'd3: begin iorq_n = 0; rd_n = 0; di = d; end
      3'd4: begin iorq_n = 0; wr_n = 0; dout = d; end
      3'd5: begin m1_n = 0; iorq_n = 0; di = d; end
      default: ;
    endcase
  endtask

  task automatic run_cycle(input logic [2:0] k, input logic [15:0] a, input logic [7:0] d,
                           input int n, input logic ready_end, output logic [TSW-1:0] ts);
    ts = tsm;
    bus_drive(k, a, d);
    repeat (n) @(negedge clk);
    bus_idle();
    rec_ready = ready_end;
    @(negedge clk);
    rec_ready = 1'b0;
  endtask

  task automatic do_reset();
    bus_idle(); rec_ready = 0; en = 1; reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic pop_head();
    rec_ready = 1'b1;
    @(negedge clk);
    rec_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus_idle(); reset = 1; en = 1;
    repeat (2) @(negedge clk);
    chk_cnt++; if (rec_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", rec_valid); else pass_cnt++;
    chk_cnt++; if (rec_count !== 5'd0) $display("FAIL rst_count: got %0d expected 0", rec_count); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %b expected 0", overflow); else pass_cnt++;
    chk_cnt++; if (drop_cnt !== 8'd0) $display("FAIL rst_drop: got %0d expected 0", drop_cnt); else pass_cnt++;
    chk_cnt++; if (rec_data !== '0) $display("FAIL rst_data: got %h expected 0", rec_data); else pass_cnt++;
    reset = 0;
  endtask

  task automatic test_opfetch();
    logic [TSW-1:0] ts;
    logic [RW-1:0] exp;
    do_reset();
    run_cycle(3'd0, 16'h0000, 8'hFD, 2, 1'b0, ts);
    exp = {TSW'(1), 3'd0, 16'h0000, 8'hFD};
    chk_cnt++; if (rec_count !== 5'd1) $display("FAIL opf_count: got %0d expected 1", rec_count); else pass_cnt++;
    chk_cnt++; if (rec_data !== exp) $display("FAIL opf_rec: got %h expected %h", rec_data, exp); else pass_cnt++;
    pop_head();
    bus_idle(); A = 16'h0002; mreq_n = 0; rfsh_n = 0;
    repeat (2) @(negedge clk);
    bus_idle();
    repeat (2) @(negedge clk);
    chk_cnt++; if (rec_count !== 5'd0) $display("FAIL rfsh_count: got %0d expected 0", rec_count); else pass_cnt++;
    chk_cnt++; if (rec_valid !== 1'b0) $display("FAIL rfsh_valid: got %b expected 0", rec_valid); else pass_cnt++;
  endtask

  task automatic test_writes_io();
    logic [TSW-1:0] t0, t1, t2;
    logic [RW-1:0] e0, e1, e2;
    run_cycle(3'd2, 16'h6DA4, 8'hD6, 2, 1'b0, t0);
    run_cycle(3'd4, 16'h1096, 8'h3C, 2, 1'b0, t1);
    run_cycle(3'd5, 16'h0038, 8'hFF, 3, 1'b0, t2);
    e0 = {t0, 3'd2, 16'h6DA4, 8'hD6};
    e1 = {t1, 3'd4, 16'h1096, 8'h3C};
    e2 = {t2, 3'd5, 16'h0038, 8'hFF};
    chk_cnt++; if (rec_count !== 5'd3) $display("FAIL wr_count: got %0d expected 3", rec_count); else pass_cnt++;
    chk_cnt++; if (rec_data !== e0) $display("FAIL memwr_rec: got %h expected %h", rec_data, e0); else pass_cnt++;
    pop_head();
    chk_cnt++; if (rec_data !== e1) $display("FAIL iowr_rec: got %h expected %h", rec_data, e1); else pass_cnt++;
    pop_head();
    chk_cnt++; if (rec_data !== e2) $display("FAIL intack_rec: got %h expected %h", rec_data, e2); else pass_cnt++;
    pop_head();
  endtask

  task automatic test_back_to_back();
    logic [TSW-1:0] t0;
    logic [RW-1:0] e0, e1;
    t0 = tsm;
    bus_drive(3'd1, 16'h1000, 8'h11);
    repeat (2) @(negedge clk);
    bus_drive(3'd1, 16'h1001, 8'h22);
    repeat (2) @(negedge clk);
    bus_idle();
    @(negedge clk);
    e0 = {t0, 3'd1, 16'h1000, 8'h11};
    e1 = {t0 + TSW'(2), 3'd1, 16'h1001, 8'h22};
    chk_cnt++; if (rec_count !== 5'd2) $display("FAIL b2b_count: got %0d expected 2", rec_count); else pass_cnt++;
    chk_cnt++; if (rec_data !== e0) $display("FAIL b2b_first: got %h expected %h", rec_data, e0); else pass_cnt++;
    pop_head();
    chk_cnt++; if (rec_data !== e1) $display("FAIL b2b_second: got %h expected %h", rec_data, e1); else pass_cnt++;
    pop_head();
    // Write strobe arriving a clock late upgrades memrd to memwr within one record
    t0 = tsm;
    bus_idle(); A = 16'h2000; mreq_n = 0; rd_n = 0; di = 8'h00; dout = 8'h5A;
    @(negedge clk);
    rd_n = 1; wr_n = 0;
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    e0 = {t0, 3'd2, 16'h2000, 8'h5A};
    chk_cnt++; if (rec_count !== 5'd1) $display("FAIL upg_count: got %0d expected 1", rec_count); else pass_cnt++;
    chk_cnt++; if (rec_data !== e0) $display("FAIL upg_rec: got %h expected %h", rec_data, e0); else pass_cnt++;
    pop_head();
  endtask

  task automatic test_overflow();
    logic [TSW-1:0] ts_arr [18];
    logic [RW-1:0] e;
    do_reset();
    for (int i = 0; i < 18; i++)
      run_cycle(3'd1, 16'(16'h0100 + i), 8'(i), 1, 1'b0, ts_arr[i]);
    chk_cnt++; if (rec_count !== 5'd16) $display("FAIL ovf_count: got %0d expected 16", rec_count); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow); else pass_cnt++;
    chk_cnt++; if (drop_cnt !== 8'd2) $display("FAIL ovf_drop: got %0d expected 2", drop_cnt); else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      e = {ts_arr[i], 3'd1, 16'(16'h0100 + i), 8'(i)};
      chk_cnt++; if (rec_data !== e) $display("FAIL ovf_drain%0d: got %h expected %h", i, rec_data, e); else pass_cnt++;
      pop_head();
    end
    chk_cnt++; if (rec_count !== 5'd0) $display("FAIL ovf_empty: got %0d expected 0", rec_count); else pass_cnt++;
    pop_head();
    chk_cnt++; if (rec_count !== 5'd0) $display("FAIL empty_pop: got %0d expected 0", rec_count); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", overflow); else pass_cnt++;
  endtask

  task automatic test_push_pop();
    logic [TSW-1:0] ts_arr [16];
    logic [TSW-1:0] tn;
    logic [RW-1:0] e;
    do_reset();
    for (int i = 0; i < 16; i++)
      run_cycle(3'd3, 16'(16'h0200 + i), 8'(8'h80 + i), 1, 1'b0, ts_arr[i]);
    chk_cnt++; if (rec_count !== 5'd16) $display("FAIL pp_full: got %0d expected 16", rec_count); else pass_cnt++;
    run_cycle(3'd3, 16'hABCD, 8'h99, 2, 1'b1, tn);
    chk_cnt++; if (rec_count !== 5'd16) $display("FAIL pp_count: got %0d expected 16", rec_count); else pass_cnt++;
    chk_cnt++; if (drop_cnt !== 8'd0) $display("FAIL pp_drop: got %0d expected 0", drop_cnt); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b0) $display("FAIL pp_ovf: got %b expected 0", overflow); else pass_cnt++;
    e = {ts_arr[1], 3'd3, 16'h0201, 8'h81};
    chk_cnt++; if (rec_data !== e) $display("FAIL pp_head: got %h expected %h", rec_data, e); else pass_cnt++;
    repeat (15) pop_head();
    e = {tn, 3'd3, 16'hABCD, 8'h99};
    chk_cnt++; if (rec_data !== e) $display("FAIL pp_tail: got %h expected %h", rec_data, e); else pass_cnt++;
  endtask

  task automatic test_saturation();
    logic [TSW-1:0] ts;
    do_reset();
    for (int i = 0; i < 316; i++)
      run_cycle(3'd1, 16'(i), 8'(i), 1, 1'b0, ts);
    chk_cnt++; if (drop_cnt !== 8'd255) $display("FAIL sat_drop: got %0d expected 255", drop_cnt); else pass_cnt++;
    chk_cnt++; if (rec_count !== 5'd16) $display("FAIL sat_count: got %0d expected 16", rec_count); else pass_cnt++;
  endtask

  task automatic test_reset_midcycle();
    logic [RW-1:0] e;
    bus_idle(); rec_ready = 0; en = 1;
    A = 16'h3000; mreq_n = 0; rd_n = 0; di = 8'h55; reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
    bus_idle();
    @(negedge clk);
    chk_cnt++; if (rec_count !== 5'd0) $display("FAIL rmid_none: got %0d expected 0", rec_count); else pass_cnt++;
    bus_drive(3'd1, 16'h3004, 8'h77);
    repeat (2) @(negedge clk);
    bus_idle();
    @(negedge clk);
    e = {TSW'(3), 3'd1, 16'h3004, 8'h77};
    chk_cnt++; if (rec_data !== e) $display("FAIL rmid_rec: got %h expected %h", rec_data, e); else pass_cnt++;
  endtask

  task automatic test_enable();
    logic [TSW-1:0] t0;
    logic [RW-1:0] e;
    do_reset();
    en = 0;
    run_cycle(3'd1, 16'h5000, 8'hAA, 2, 1'b0, t0);
    chk_cnt++; if (rec_count !== 5'd0) $display("FAIL en_low: got %0d expected 0", rec_count); else pass_cnt++;
    en = 1;
    t0 = tsm;
    bus_drive(3'd1, 16'h4000, 8'h44);
    @(negedge clk);
    en = 0;
    @(negedge clk);
    bus_drive(3'd1, 16'h4001, 8'h45);
    repeat (2) @(negedge clk);
    bus_idle();
    @(negedge clk);
    e = {t0, 3'd1, 16'h4000, 8'h44};
    chk_cnt++; if (rec_count !== 5'd1) $display("FAIL en_fall_count: got %0d expected 1", rec_count); else pass_cnt++;
    chk_cnt++; if (rec_data !== e) $display("FAIL en_fall_rec: got %h expected %h", rec_data, e); else pass_cnt++;
    en = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_opfetch();
    test_writes_io();
    test_back_to_back();
    test_overflow();
    test_push_pop();
    test_saturation();
    test_reset_midcycle();
    test_enable();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
